// File: rtl/trojan_bist_pkg.sv
// trojan_bist_pkg: shared states, default MISR constants and the serial MISR step function
package trojan_bist_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, COMPARE} state_t;
  localparam int MAX_W = 64;
  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'h0000;
  // Galois step on the low w bits; also intended for the upstream pattern LFSR
  function automatic logic [MAX_W-1:0] misr_step(
    input logic [MAX_W-1:0] sig,
    input logic [MAX_W-1:0] poly,
    input int               w,
    input logic             b
  );
    logic fb;
    fb = b ^ (|(sig & (MAX_W'(1) << (w - 1))));
    return ((sig << 1) ^ (fb ? poly : '0)) & ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction
endpackage

// File: rtl/misr_serial.sv
// misr_serial: single-input signature register, load has priority over shift
module misr_serial
  import trojan_bist_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [SIG_W-1:0] o_sig
);
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_next;
  assign w_next = SIG_W'(misr_step(MAX_W'(r_sig), MAX_W'(POLY), SIG_W, i_bit));
  always_ff @(posedge clk)
    if (rst || i_load) r_sig <= SEED;
    else if (i_en) r_sig <= w_next;
  assign o_sig = r_sig;
endmodule

// File: rtl/resp_misr_analyzer.sv
// resp_misr_analyzer: compacts a window of response bits into a MISR and flags a golden mismatch
module resp_misr_analyzer
  import trojan_bist_pkg::*;
#(
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
  parameter int               WINDOW = 256,
  localparam int              CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic             resp_bit,
  input  logic [SIG_W-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] bit_cnt
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic             r_done, r_mismatch, w_start, w_accept, w_cmp;
  always_comb begin
    w_start   = (r_state == IDLE) && start;
    w_accept  = (r_state == COLLECT) && resp_valid && !abort;
    w_cmp     = (r_state == COMPARE) && !abort;
    w_cnt_inc = r_cnt + CNT_W'(1);
    w_next    = r_state == IDLE ? (start ? COLLECT : IDLE)
              : abort || r_state == COMPARE ? IDLE
              : w_accept && w_cnt_inc == CNT_W'(WINDOW) ? COMPARE
              : COLLECT;
  end
  always_ff @(posedge I1470_clk)
    if (I1477_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_start ? '0 : w_accept ? w_cnt_inc : r_cnt;
      r_done     <= w_cmp;
      r_mismatch <= w_start ? 1'b0 : w_cmp ? (signature != golden_sig) : r_mismatch;
    end
  misr_serial #(.SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_misr (
    .clk    (I1470_clk),
    .rst    (I1477_rst),
    .i_load (w_start),
    .i_en   (w_accept),
    .i_bit  (resp_bit),
    .o_sig  (signature)
  );
  assign busy     = r_state != IDLE;
  assign done     = r_done;
  assign mismatch = r_mismatch;
  assign bit_cnt  = r_cnt;
endmodule

// File: tb/tb_resp_misr_analyzer.sv
// tb_resp_misr_analyzer: directed scenarios for a 4-bit window with hand-computed CRC-16 signatures
module tb_resp_misr_analyzer;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic        resp_valid = 1'b0, resp_bit = 1'b0;
  logic [15:0] golden_sig = 16'h0000;
  logic        busy, done, mismatch;
  logic [15:0] signature;
  logic [2:0]  bit_cnt;
  int          n_cmp = 0, n_bad = 0;

  resp_misr_analyzer #(.WINDOW(4)) dut (
    .I1470_clk  (clk),
    .I1477_rst  (rst),
    .start      (start),
    .abort      (abort),
    .resp_valid (resp_valid),
    .resp_bit   (resp_bit),
    .golden_sig (golden_sig),
    .busy       (busy),
    .done       (done),
    .mismatch   (mismatch),
    .signature  (signature),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic b);
    resp_valid = 1'b1;
    resp_bit   = b;
    tick();
    resp_valid = 1'b0;
    resp_bit   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL reset_mismatch: got %b want 0", mismatch); end
    n_cmp++; if (signature !== 16'h0000) begin n_bad++; $display("FAIL reset_sig: got %h want 0000", signature); end
    n_cmp++; if (bit_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bit_cnt); end
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_idle: busy %b done %b want 0 0", busy, done); end
  endtask

  task automatic test_match();
    golden_sig = 16'h8108;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || bit_cnt !== 3'd0) begin n_bad++; $display("FAIL match_start: busy %b cnt %0d want 1 0", busy, bit_cnt); end
    feed(1'b1);
    n_cmp++; if (signature !== 16'h1021) begin n_bad++; $display("FAIL match_step1: got %h want 1021", signature); end
    feed(1'b0);
    n_cmp++; if (signature !== 16'h2042) begin n_bad++; $display("FAIL match_step2: got %h want 2042", signature); end
    feed(1'b0);
    n_cmp++; if (signature !== 16'h4084) begin n_bad++; $display("FAIL match_step3: got %h want 4084", signature); end
    feed(1'b0);
    n_cmp++; if (signature !== 16'h8108 || bit_cnt !== 3'd4) begin n_bad++; $display("FAIL match_step4: sig %h cnt %0d want 8108 4", signature, bit_cnt); end
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL match_compare: busy %b done %b want 1 0", busy, done); end
    tick();
    n_cmp++; if (done !== 1'b1 || mismatch !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL match_verdict: done %b mis %b busy %b want 1 0 0", done, mismatch, busy); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL match_done_pulse: got %b want 0", done); end
    n_cmp++; if (signature !== 16'h8108 || bit_cnt !== 3'd4) begin n_bad++; $display("FAIL match_hold: sig %h cnt %0d want 8108 4", signature, bit_cnt); end
  endtask

  task automatic test_mismatch();
    golden_sig = 16'h8109;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(1'b1);
    feed(1'b0);
    feed(1'b0);
    feed(1'b0);
    tick();
    n_cmp++; if (done !== 1'b1 || mismatch !== 1'b1) begin n_bad++; $display("FAIL mis_verdict: done %b mis %b want 1 1", done, mismatch); end
    tick();
    tick();
    n_cmp++; if (mismatch !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL mis_hold: mis %b done %b want 1 0", mismatch, done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (mismatch !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL mis_clear: mis %b busy %b want 0 1", mismatch, busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_gaps();
    golden_sig = 16'h8108;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(1'b1);
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (signature !== 16'h1021 || bit_cnt !== 3'd1) begin n_bad++; $display("FAIL gap1: sig %h cnt %0d want 1021 1", signature, bit_cnt); end
    feed(1'b0);
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (signature !== 16'h2042 || bit_cnt !== 3'd2) begin n_bad++; $display("FAIL gap2: sig %h cnt %0d want 2042 2", signature, bit_cnt); end
    feed(1'b0);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL gap_early: done %b busy %b want 0 1", done, busy); end
    feed(1'b0);
    tick();
    n_cmp++; if (done !== 1'b1 || mismatch !== 1'b0 || signature !== 16'h8108) begin n_bad++; $display("FAIL gap_verdict: done %b mis %b sig %h want 1 0 8108", done, mismatch, signature); end
  endtask

  task automatic test_abort();
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(1'b1);
    feed(1'b0);
    abort = 1'b1;
    resp_valid = 1'b1;
    tick();
    abort = 1'b0;
    resp_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_idle: busy %b done %b want 0 0", busy, done); end
    n_cmp++; if (signature !== 16'h2042 || bit_cnt !== 3'd2) begin n_bad++; $display("FAIL abort_frozen: sig %h cnt %0d want 2042 2", signature, bit_cnt); end
    tick();
    n_cmp++; if (done !== 1'b0 || signature !== 16'h2042) begin n_bad++; $display("FAIL abort_nodone: done %b sig %h want 0 2042", done, signature); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (signature !== 16'h0000 || bit_cnt !== 3'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL abort_restart: sig %h cnt %0d busy %b want 0000 0 1", signature, bit_cnt, busy); end
  endtask

  task automatic test_start_ignored_and_reset();
    feed(1'b1);
    start = 1'b1;
    feed(1'b0);
    start = 1'b0;
    n_cmp++; if (bit_cnt !== 3'd2 || signature !== 16'h2042) begin n_bad++; $display("FAIL start_ignored: cnt %0d sig %h want 2 2042", bit_cnt, signature); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || mismatch !== 1'b0) begin n_bad++; $display("FAIL midrst_flags: busy %b done %b mis %b want 0 0 0", busy, done, mismatch); end
    n_cmp++; if (signature !== 16'h0000 || bit_cnt !== 3'd0) begin n_bad++; $display("FAIL midrst_state: sig %h cnt %0d want 0000 0", signature, bit_cnt); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_nodone: done %b busy %b want 0 0", done, busy); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_gaps();
    test_abort();
    test_start_ignored_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
